// File: rtl/reg_mem_pkg.sv
// Shared constants and the address range helper for the reg_mem register file.
package reg_mem_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_BITS  = 32;
    localparam int DEFAULT_DEPTH      = 32;

    // Full-width compare so upper address bits can never alias onto a real word.
    function automatic logic addr_in_range(input logic [63:0] addr, input logic [63:0] depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/reg_mem.sv
// Flip-flop register file: one shared address, synchronous write, combinational read,
// contents cleared by asynchronous active-low reset.
module reg_mem
    import reg_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_BITS  = DEFAULT_ADDR_BITS,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wen,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH < 1) begin : g_bad_depth
        $error("reg_mem: DEPTH must be at least 1");
    end
    if (ADDR_BITS < 1 || ADDR_BITS > 64) begin : g_bad_addr_bits
        $error("reg_mem: ADDR_BITS must be in 1..64");
    end
    if (((64'(DEPTH) - 64'd1) >> ADDR_BITS) != 64'd0) begin : g_depth_too_big
        $error("reg_mem: DEPTH-1 is not representable in ADDR_BITS");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  in_range;
    logic [IDX_W-1:0]      idx;

    assign in_range = addr_in_range(64'(addr), 64'(DEPTH));
    assign idx      = addr[IDX_W-1:0];

    // NOTE: the whole array is reset here on purpose; a reset loop over a memory
    // forces flip-flops and rules out block-RAM inference, which is what we want.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wen && in_range) begin
            mem[idx] <= data_in;
        end
    end

    // NOTE: assign a default before the conditional so no path leaves data_out
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        data_out = '0;
        if (in_range) begin
            data_out = mem[idx];
        end
    end

endmodule

// File: tb/tb_reg_mem.sv
// Directed self-checking bench for reg_mem: reset, write/readback, inhibit,
// read-during-write, out-of-range writes and asynchronous reset mid-operation.
module tb_reg_mem;

    localparam int DW = 8;
    localparam int AW = 32;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in;
    logic          wen;
    logic [DW-1:0] data_out;

    logic [DW-1:0] model [DEPTH];
    int            n_checks = 0;
    int            n_passed = 0;

    reg_mem #(.DATA_WIDTH(DW), .ADDR_BITS(AW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .data_in  (data_in),
        .wen      (wen),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            addr = AW'(a);
            #1;
            check($sformatf("%s addr=%0d", tag, a), data_out, model[a]);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        wen     = 1'b0;
        addr    = '0;
        data_in = '0;
        for (int a = 0; a < DEPTH; a++) model[a] = '0;

        // Reset held for two cycles, released away from the rising edge.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sweep("reset");

        // Write 10..17 into addresses 12..19, one per cycle.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            addr    = AW'(12 + i);
            data_in = DW'(10 + i);
            wen     = 1'b1;
            model[12 + i] = DW'(10 + i);
            @(posedge clk);
        end
        @(negedge clk);
        wen = 1'b0;
        sweep("readback");

        // wen low: data_in ignored.
        addr    = 32'd12;
        data_in = 8'hAA;
        @(posedge clk);
        #1;
        check("inhibit addr=12", data_out, 8'd10);

        // Read-during-write: old value before the edge, new value after.
        @(negedge clk);
        addr    = 32'd15;
        data_in = 8'h55;
        wen     = 1'b1;
        #1;
        check("rdw before edge", data_out, 8'd13);
        @(posedge clk);
        #1;
        check("rdw after edge", data_out, 8'h55);
        model[15] = 8'h55;

        // Out-of-range writes must change nothing, including aliased low bits.
        @(negedge clk);
        addr    = 32'd32;
        data_in = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        addr = 32'h8000_000C;
        @(posedge clk);
        @(negedge clk);
        wen  = 1'b0;
        addr = 32'd32;
        #1;
        check("oor addr=32", data_out, 8'h00);
        addr = 32'h8000_000C;
        #1;
        check("oor addr=0x8000000C", data_out, 8'h00);
        addr = 32'hFFFF_FFFF;
        #1;
        check("oor addr=max", data_out, 8'h00);
        sweep("after oor");

        // Asynchronous reset between edges clears immediately.
        @(negedge clk);
        addr = 32'd12;
        #1;
        check("pre-reset addr=12", data_out, 8'd10);
        rst_n = 1'b0;
        #1;
        check("async reset addr=12", data_out, 8'h00);
        for (int a = 0; a < DEPTH; a++) model[a] = '0;

        // Write attempt while reset is held.
        data_in = 8'h77;
        wen     = 1'b1;
        @(posedge clk);
        #1;
        check("write in reset addr=12", data_out, 8'h00);
        @(negedge clk);
        wen   = 1'b0;
        rst_n = 1'b1;
        sweep("after release");

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
